// File: rtl/baseline_tracker_if.sv
// Sample/trigger inputs and pedestal outputs of the baseline tracker.
// The bench drives the master side and the tracker implements the slave side.
interface baseline_tracker_if;
  logic        en;
  logic [13:0] adc_dat;
  logic        trig_in;
  logic [13:0] baseline;
  logic        baseline_valid;
  logic [15:0] abort_cnt;

  modport master (
    output en, adc_dat, trig_in,
    input  baseline, baseline_valid, abort_cnt
  );

  modport slave (
    input  en, adc_dat, trig_in,
    output baseline, baseline_valid, abort_cnt
  );
endinterface

// File: rtl/baseline_tracker.sv
// ADC pedestal estimator: block-averages 2^LOG2N samples. It freezes during
// triggers plus a holdoff window, and drops windows with large positive excursions.
module baseline_tracker #(
  parameter int LOG2N   = 6,
  parameter int HOLDOFF = 128,
  parameter int REJECT  = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  baseline_tracker_if.slave  bus
);

  localparam int AW = 14 + LOG2N;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [LOG2N-1:0] CNT_LAST  = '1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLDOFF - 1);
  localparam logic [14:0]      REJECT_W  = 15'(REJECT);

  typedef enum logic [1:0] {S_INIT, S_TRACK, S_HOLD, S_HOLDOFF} state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     acc_reg, acc_next;
  logic [LOG2N-1:0]  cnt_reg, cnt_next;
  logic [HW-1:0]     hcnt_reg, hcnt_next;
  logic [13:0]       s_q;
  logic [13:0]       baseline_reg, baseline_next;
  logic              valid_reg, valid_next;
  logic [15:0]       abort_reg, abort_next;

  logic [AW-1:0]     acc_sum;
  logic [14:0]       reject_lim;
  logic              excursion;

  // The limit is computed in 15 bits so a baseline near full scale cannot wrap.
  assign acc_sum    = acc_reg + AW'(s_q);
  assign reject_lim = {1'b0, baseline_reg} + REJECT_W;
  assign excursion  = ({1'b0, s_q} > reject_lim);

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    hcnt_next     = hcnt_reg;
    baseline_next = baseline_reg;
    valid_next    = valid_reg;
    abort_next    = abort_reg;

    case (state_reg)
      S_INIT, S_TRACK: begin
        if (bus.trig_in) begin
          state_next = S_HOLD;
          acc_next   = '0;
          cnt_next   = '0;
        end else if (!bus.en) begin
          acc_next = '0;
          cnt_next = '0;
        end else if (state_reg == S_TRACK && excursion) begin
          acc_next = '0;
          cnt_next = '0;
          if (abort_reg != 16'hFFFF) abort_next = abort_reg + 16'd1;
        end else if (cnt_reg == CNT_LAST) begin
          baseline_next = acc_sum[AW-1:LOG2N];
          valid_next    = 1'b1;
          acc_next      = '0;
          cnt_next      = '0;
          state_next    = S_TRACK;
        end else begin
          acc_next = acc_sum;
          cnt_next = cnt_reg + LOG2N'(1);
        end
      end

      S_HOLD: begin
        acc_next = '0;
        cnt_next = '0;
        if (!bus.trig_in) begin
          state_next = S_HOLDOFF;
          hcnt_next  = '0;
        end
      end

      S_HOLDOFF: begin
        acc_next = '0;
        cnt_next = '0;
        if (bus.trig_in) begin
          state_next = S_HOLD;
        end else if (hcnt_reg == HOLD_LAST) begin
          state_next = valid_reg ? S_TRACK : S_INIT;
          hcnt_next  = '0;
        end else begin
          hcnt_next = hcnt_reg + HW'(1);
        end
      end

      default: state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_INIT;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      hcnt_reg     <= '0;
      s_q          <= '0;
      baseline_reg <= '0;
      valid_reg    <= 1'b0;
      abort_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      hcnt_reg     <= hcnt_next;
      s_q          <= bus.adc_dat;
      baseline_reg <= baseline_next;
      valid_reg    <= valid_next;
      abort_reg    <= abort_next;
    end
  end

  assign bus.baseline       = baseline_reg;
  assign bus.baseline_valid = valid_reg;
  assign bus.abort_cnt      = abort_reg;

endmodule
